// File: rtl/clock_mon_pkg.sv
// Shared constants and FSM state encoding for clock monitoring blocks.
package clock_mon_pkg;

  localparam int unsigned DEF_WIDTH      = 8;
  localparam int unsigned DEF_LOCK_COUNT = 4;
  localparam int unsigned DEF_MAX_PERIOD = 255;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_TRACK  = 3'd2,
    ST_LOCKED = 3'd3,
    ST_LOST   = 3'd4
  } mon_state_e;

endpackage

// File: rtl/clock_edge_detect.sv
// Rising-edge detector for the monitored clock; CLOCK_MON_SYNC_EN inserts a
// 2-flop synchroniser ahead of the edge detect so div_in may be asynchronous.
module clock_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic rise
);

  logic div_s;
  logic div_d;
  logic div_q;

`ifdef CLOCK_MON_SYNC_EN
  logic [1:0] sync_d;
  logic [1:0] sync_q;

  always_comb begin
    sync_d = {sync_q[0], d_in};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign div_s = sync_q[1];
`else
  assign div_s = d_in;
`endif

  always_comb begin
    div_d = div_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) div_q <= 1'b0;
    else     div_q <= div_d;
  end

  assign rise = div_s & ~div_q;

endmodule

// File: rtl/clock_ratio_monitor.sv
// Measures div_in period in in_clk cycles, locks once the period is stable and
// flags sticky loss on timeout. CLOCK_MON_SYNC_EN enables input synchronisation.
module clock_ratio_monitor
  import clock_mon_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned LOCK_COUNT = DEF_LOCK_COUNT,
  parameter int unsigned MAX_PERIOD = DEF_MAX_PERIOD
) (
  input  logic             in_clk,
  input  logic             reset,
  input  logic             div_in,
  input  logic             clr,
  output logic [WIDTH-1:0] ratio,
  output logic             ratio_valid,
  output logic             locked,
  output logic             lost
);

  localparam int unsigned MW = $clog2(LOCK_COUNT + 1);
  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_PERIOD);
  localparam logic [MW-1:0]    LOCK_M  = MW'(LOCK_COUNT);

  logic rise;

  mon_state_e       state_d, state_q;
  logic [WIDTH-1:0] cnt_d, cnt_q;
  logic [WIDTH-1:0] ref_d, ref_q;
  logic [MW-1:0]    match_d, match_q;
  logic [WIDTH-1:0] ratio_d, ratio_q;
  logic             locked_d, locked_q;
  logic             lost_d, lost_q;
  logic             cnt_sat;
  logic             timeout;

  clock_edge_detect u_edge (
    .clk  (in_clk),
    .rst  (reset),
    .d_in (div_in),
    .rise (rise)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ref_d   = ref_q;
    match_d = match_q;
    ratio_d = ratio_q;
    lost_d  = lost_q;

    cnt_sat = (cnt_q == MAX_CNT);
    // LOST is excluded so clr can release the flag while div_in stays dead
    timeout = cnt_sat && !rise &&
              (state_q == ST_ARM || state_q == ST_TRACK || state_q == ST_LOCKED);

    if (state_q == ST_IDLE)  cnt_d = rise ? WIDTH'(1) : '0;
    else if (rise)           cnt_d = WIDTH'(1);
    else if (!cnt_sat)       cnt_d = cnt_q + WIDTH'(1);

    case (state_q)
      ST_IDLE: if (rise) state_d = ST_ARM;
      ST_ARM: begin
        if (rise) begin
          state_d = ST_TRACK;
          ref_d   = cnt_q;
          ratio_d = cnt_q;
          match_d = MW'(1);
        end else if (timeout) begin
          state_d = ST_LOST;
        end
      end
      ST_TRACK: begin
        if (rise) begin
          ratio_d = cnt_q;
          if (cnt_q == ref_q) begin
            match_d = match_q + MW'(1);
            if (match_q + MW'(1) == LOCK_M) state_d = ST_LOCKED;
          end else begin
            ref_d   = cnt_q;
            match_d = MW'(1);
          end
        end else if (timeout) begin
          state_d = ST_LOST;
        end
      end
      ST_LOCKED: begin
        if (rise) begin
          ratio_d = cnt_q;
          if (cnt_q != ref_q) begin
            state_d = ST_TRACK;
            ref_d   = cnt_q;
            match_d = MW'(1);
          end
        end else if (timeout) begin
          state_d = ST_LOST;
        end
      end
      ST_LOST: if (rise) state_d = ST_ARM;
      default: state_d = ST_IDLE;
    endcase

    if (timeout)  lost_d = 1'b1;
    else if (clr) lost_d = 1'b0;

    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge in_clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      ref_q    <= '0;
      match_q  <= '0;
      ratio_q  <= '0;
      locked_q <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ref_q    <= ref_d;
      match_q  <= match_d;
      ratio_q  <= ratio_d;
      locked_q <= locked_d;
      lost_q   <= lost_d;
    end
  end

  assign ratio       = ratio_q;
  assign ratio_valid = locked_q;
  assign locked      = locked_q;
  assign lost        = lost_q;

endmodule

// File: tb/tb_clock_ratio_monitor.sv
// Self-checking bench for clock_ratio_monitor: period/lock/loss model plus literal spot checks.
module tb_clock_ratio_monitor;

  localparam int WIDTH = 8;
  localparam int LOCKN = 4;
  localparam int MAXP  = 255;
`ifdef CLOCK_MON_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic             in_clk;
  logic             reset;
  logic             div_in;
  logic             clr;
  logic [WIDTH-1:0] ratio;
  logic             ratio_valid;
  logic             locked;
  logic             lost;

  clock_ratio_monitor #(
    .WIDTH      (WIDTH),
    .LOCK_COUNT (LOCKN),
    .MAX_PERIOD (MAXP)
  ) dut (
    .in_clk      (in_clk),
    .reset       (reset),
    .div_in      (div_in),
    .clr         (clr),
    .ratio       (ratio),
    .ratio_valid (ratio_valid),
    .locked      (locked),
    .lost        (lost)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  int n_chk  = 0;
  int n_fail = 0;
  int unsigned cyc = 0;

  task automatic check(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Model: edges seen through LAT cycles of input delay, periods measured as
  // cycles between rises, lock = last LOCKN periods since arming all equal.
  bit  hist[$];
  bit  prev_s;
  bit  armed;
  int  elapsed;
  int  periods[$];
  int  m_ratio;
  bit  m_lost;

  function automatic bit model_locked();
    if (periods.size() < LOCKN) return 1'b0;
    foreach (periods[i]) if (periods[i] != periods[periods.size()-1]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i <= LAT; i++) hist.push_back(1'b0);
    prev_s = 1'b0; armed = 1'b0; elapsed = 0;
    periods.delete(); m_ratio = 0; m_lost = 1'b0;
  endtask

  initial begin
    bit s, r, to;
    model_reset();
    forever begin
      @(posedge in_clk or posedge reset);
      if (reset) begin
        model_reset();
      end else begin
        hist.push_front(div_in);
        s = hist[LAT];
        void'(hist.pop_back());
        r = s && !prev_s;
        prev_s = s;
        to = 1'b0;
        if (armed) elapsed++;
        if (r) begin
          if (!armed) begin
            armed = 1'b1; elapsed = 0; periods.delete();
          end else begin
            m_ratio = elapsed;
            periods.push_back(elapsed);
            if (periods.size() > LOCKN) void'(periods.pop_front());
            elapsed = 0;
          end
        end else if (armed && elapsed >= MAXP) begin
          to = 1'b1; armed = 1'b0; periods.delete();
        end
        if (to) m_lost = 1'b1;
        else if (clr) m_lost = 1'b0;
      end
    end
  end

  initial forever begin
    @(posedge in_clk);
    cyc++;
  end

  typedef struct {
    int unsigned due;
    int          sel;
    int          exp;
    string       nm;
  } lit_t;
  lit_t pend[$];

  // Literal expectations are due LAT cycles after the point they are queued.
  task automatic expect_lit(input string nm, input int sel, input int exp);
    lit_t e;
    e.due = cyc + LAT; e.sel = sel; e.exp = exp; e.nm = nm;
    pend.push_back(e);
  endtask

  initial forever begin
    @(negedge in_clk);
    check("ratio",       int'(ratio),  m_ratio);
    check("locked",      int'(locked), int'(model_locked()));
    check("ratio_valid", int'(ratio_valid), int'(model_locked()));
    check("lost",        int'(lost),   int'(m_lost));
    while (pend.size() > 0 && pend[0].due <= cyc) begin
      lit_t e;
      int got;
      e = pend.pop_front();
      got = (e.sel == 0) ? int'(ratio) : (e.sel == 1) ? int'(locked) : int'(lost);
      check(e.nm, got, e.exp);
    end
  end

  task automatic drive(input logic v, input logic c);
    @(posedge in_clk);
    #1;
    div_in = v;
    clr    = c;
  endtask

  task automatic train(input int per, input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 1'b0);
      for (int j = 1; j < per; j++) drive(1'b0, 1'b0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; div_in = 1'b0; clr = 1'b0;
    repeat (3) @(posedge in_clk);
    #1 reset = 1'b0;
    check("reset_ratio",  int'(ratio),  0);
    check("reset_locked", int'(locked), 0);
    check("reset_lost",   int'(lost),   0);
    repeat (3) drive(1'b0, 1'b0);

    // /3 source: arming edge + 4 equal periods
    train(3, 4);
    expect_lit("t1_not_yet_locked", 1, 0);
    expect_lit("t1_ratio", 0, 3);
    train(3, 1);
    expect_lit("t1_locked", 1, 1);
    expect_lit("t1_lost", 2, 0);

    // switch to period 5
    train(5, 2);
    expect_lit("t2_unlock", 1, 0);
    expect_lit("t2_ratio", 0, 5);
    train(5, 2);
    expect_lit("t2_still_tracking", 1, 0);
    train(5, 1);
    expect_lit("t2_relock", 1, 1);

    // dead input: timeout at cnt==255, clr in the timeout cycle loses
    repeat (250) drive(1'b0, 1'b0);
    expect_lit("t3_pre_timeout_locked", 1, 1);
    expect_lit("t3_pre_timeout_lost", 2, 0);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    expect_lit("t3_lost_set", 2, 1);
    expect_lit("t3_unlocked", 1, 0);
    repeat (5) drive(1'b0, 1'b0);
    train(3, 4);
    expect_lit("t3_rearm_unlocked", 1, 0);
    train(3, 1);
    expect_lit("t3_relock", 1, 1);
    expect_lit("t3_lost_sticky", 2, 1);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    expect_lit("t3_lost_cleared", 2, 0);

    // period exactly MAX_PERIOD is a measurement, not a timeout
    train(255, 5);
    expect_lit("t4_ratio_max", 0, 255);
    expect_lit("t4_locked", 1, 1);
    expect_lit("t4_lost", 2, 0);
    repeat (LAT + 1) drive(1'b0, 1'b0);

    // async reset while locked
    @(posedge in_clk);
    #2 reset = 1'b1;
    #1;
    check("t5_reset_ratio",       int'(ratio), 0);
    check("t5_reset_locked",      int'(locked), 0);
    check("t5_reset_ratio_valid", int'(ratio_valid), 0);
    check("t5_reset_lost",        int'(lost), 0);
    @(posedge in_clk);
    #1 reset = 1'b0;
    repeat (2) drive(1'b0, 1'b0);
    train(3, 4);
    expect_lit("t5_not_yet_locked", 1, 0);
    train(3, 1);
    expect_lit("t5_relock", 1, 1);
    expect_lit("t5_ratio", 0, 3);

    repeat (LAT + 4) drive(1'b0, 1'b0);
    if (pend.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL pending_literals: got %0d unchecked, expected 0", pend.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
